// File: rtl/cfg_bus_arbiter_pkg.sv
// Shared types and constants for the configuration bus arbiter.
// Target codes, FSM state encoding and parameter defaults.
package cfg_bus_arbiter_pkg;

  localparam int unsigned N_REQ_DEF   = 4;
  localparam int unsigned ADDR_W_DEF  = 4;
  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned TIMEOUT_DEF = 255;

  localparam logic [1:0] TGT_UART = 2'b01;
  localparam logic [1:0] TGT_VGA  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  function automatic logic tgt_legal(
    input logic [1:0] tgt
  );
    return (tgt == TGT_UART) || (tgt == TGT_VGA);
  endfunction

endpackage

// File: rtl/cfg_bus_arbiter_if.sv
// Requester and config-bus signal bundle for cfg_bus_arbiter.
// slave = arbiter view, master = requesters plus bus target.
interface cfg_bus_arbiter_if
  import cfg_bus_arbiter_pkg::*;
#(
  parameter int N_REQ             = N_REQ_DEF,
  parameter int WIDTH_CONFIG_ADDR = ADDR_W_DEF,
  parameter int WIDTH_CONFIG_DATA = DATA_W_DEF
);
  localparam int A  = WIDTH_CONFIG_ADDR;
  localparam int D  = WIDTH_CONFIG_DATA;
  localparam int GW = $clog2(N_REQ);

  logic [N_REQ*A-1:0] req_addr;
  logic [N_REQ*D-1:0] req_data;
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ-1:0]   req_error;
  logic [A-1:0]       c_addr;
  logic [D-1:0]       c_data;
  logic               c_valid;
  logic               c_ready;
  logic [GW-1:0]      grant_id;
  logic               busy;

  modport master (
    output req_addr, req_data, req_valid,
    output c_ready,
    input  req_ready, req_error,
    input  c_addr, c_data, c_valid,
    input  grant_id, busy
  );

  modport slave (
    input  req_addr, req_data, req_valid,
    input  c_ready,
    output req_ready, req_error,
    output c_addr, c_data, c_valid,
    output grant_id, busy
  );

endinterface

// File: rtl/cfg_bus_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Scans ptr+1 .. ptr (mod N) and returns the first requester found.
module cfg_bus_arbiter_rr_pick #(
  parameter int N  = 4,
  parameter int GW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] ptr,
  output logic [GW-1:0] gnt,
  output logic          any
);

  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    any   = |req;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        gnt   = GW'(idx);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cfg_bus_arbiter.sv
// Round-robin owner of the shared config bus: grant, decode,
// issue, wait out the target busy window, report completion.
module cfg_bus_arbiter
  import cfg_bus_arbiter_pkg::*;
#(
  parameter int N_REQ             = N_REQ_DEF,
  parameter int WIDTH_CONFIG_ADDR = ADDR_W_DEF,
  parameter int WIDTH_CONFIG_DATA = DATA_W_DEF,
  parameter int TIMEOUT           = TIMEOUT_DEF
) (
  input logic              clk,
  input logic              rst_n,
  cfg_bus_arbiter_if.slave bus
);

  localparam int A  = WIDTH_CONFIG_ADDR;
  localparam int D  = WIDTH_CONFIG_DATA;
  localparam int GW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state;
  logic [GW-1:0] ptr;
  logic [GW-1:0] gnt;
  logic          any;
  logic [CW-1:0] cnt;
  logic [A-1:0]  pick_addr;
  logic [D-1:0]  pick_data;
  logic          tmo;

  cfg_bus_arbiter_rr_pick #(
    .N  (N_REQ),
    .GW (GW)
  ) u_pick (
    .req (bus.req_valid),
    .ptr (ptr),
    .gnt (gnt),
    .any (any)
  );

  assign pick_addr = bus.req_addr[int'(gnt)*A +: A];
  assign pick_data = bus.req_data[int'(gnt)*D +: D];
  assign tmo       = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      ptr           <= GW'(N_REQ - 1);
      cnt           <= '0;
      bus.c_addr    <= '0;
      bus.c_data    <= '0;
      bus.c_valid   <= 1'b0;
      bus.req_ready <= '0;
      bus.req_error <= '0;
      bus.grant_id  <= '0;
      bus.busy      <= 1'b0;
    end else begin
      bus.req_ready <= '0;
      bus.req_error <= '0;
      unique case (state)
        ST_IDLE: begin
          if (any) begin
            bus.c_addr   <= pick_addr;
            bus.c_data   <= pick_data;
            bus.grant_id <= gnt;
            bus.busy     <= 1'b1;
            ptr          <= gnt;
            if (tgt_legal(pick_addr[A-1:A-2])) begin
              state       <= ST_ISSUE;
              bus.c_valid <= 1'b1;
              cnt         <= '0;
            end else begin
              state              <= ST_DONE;
              bus.req_ready[gnt] <= 1'b1;
              bus.req_error[gnt] <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          cnt <= cnt + 1'b1;
          // A handshake on the last allowed cycle still counts as progress
          if (bus.c_ready) begin
            state       <= ST_WAIT;
            bus.c_valid <= 1'b0;
          end else if (tmo) begin
            state                       <= ST_DONE;
            bus.c_valid                 <= 1'b0;
            bus.req_ready[bus.grant_id] <= 1'b1;
            bus.req_error[bus.grant_id] <= 1'b1;
          end
        end
        ST_WAIT: begin
          cnt <= cnt + 1'b1;
          if (bus.c_ready) begin
            state                       <= ST_DONE;
            bus.req_ready[bus.grant_id] <= 1'b1;
          end else if (tmo) begin
            state                       <= ST_DONE;
            bus.req_ready[bus.grant_id] <= 1'b1;
            bus.req_error[bus.grant_id] <= 1'b1;
          end
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_bus_arbiter.sv
// Scoreboard bench for cfg_bus_arbiter: expected beats and
// completions are queued at stimulus time and popped on DUT output.
module tb_cfg_bus_arbiter;
  import cfg_bus_arbiter_pkg::*;

  localparam int N = 4;
  localparam int A = 4;
  localparam int D = 8;

  typedef struct {
    int   id;
    logic err;
  } cpl_t;

  typedef struct {
    logic [A-1:0] a;
    logic [D-1:0] d;
  } beat_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  cfg_bus_arbiter_if #(
    .N_REQ(N), .WIDTH_CONFIG_ADDR(A), .WIDTH_CONFIG_DATA(D)
  ) cb ();

  cfg_bus_arbiter_if #(
    .N_REQ(N), .WIDTH_CONFIG_ADDR(A), .WIDTH_CONFIG_DATA(D)
  ) cb2 ();

  cfg_bus_arbiter #(
    .N_REQ(N), .WIDTH_CONFIG_ADDR(A),
    .WIDTH_CONFIG_DATA(D), .TIMEOUT(255)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (cb.slave)
  );

  cfg_bus_arbiter #(
    .N_REQ(N), .WIDTH_CONFIG_ADDR(A),
    .WIDTH_CONFIG_DATA(D), .TIMEOUT(8)
  ) dut_to (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (cb2.slave)
  );

  int checks   = 0;
  int fails    = 0;
  int cyc      = 0;
  int done_cyc = -1;
  int cv_cnt   = 0;
  int done_log[$];

  logic [A-1:0] ra[N];
  logic [D-1:0] rd[N];
  logic [N-1:0] rv;
  int           rep[N];
  logic         prev_cv;

  cpl_t  cpl_q[$];
  beat_t beat_q[$];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      cb.req_addr[i*A +: A] = ra[i];
      cb.req_data[i*D +: D] = rd[i];
    end
    cb.req_valid = rv;
  endtask

  task automatic post(input int i, input logic [A-1:0] a,
                      input logic [D-1:0] d, input int n_rep = 0);
    ra[i]  = a;
    rd[i]  = d;
    rv[i]  = 1'b1;
    rep[i] = n_rep;
    drive();
  endtask

  task automatic expect_cpl(input int id, input logic err,
                            input logic [A-1:0] a,
                            input logic [D-1:0] d);
    cpl_t  c;
    beat_t b;
    c.id  = id;
    c.err = err;
    cpl_q.push_back(c);
    if (!err) begin
      b.a = a;
      b.d = d;
      beat_q.push_back(b);
    end
  endtask

  task automatic step();
    beat_t          b;
    cpl_t           c;
    int             id;
    logic [N-1:0]   exp_err;
    @(negedge clk);
    cyc++;
    if (cb.c_valid) cv_cnt++;
    if (cb.c_valid && !prev_cv) begin
      if (beat_q.size() == 0) begin
        check("beat_unexpected", 32'd1, 32'd0);
      end else begin
        b = beat_q.pop_front();
        check("c_addr", 32'(cb.c_addr), 32'(b.a));
        check("c_data", 32'(cb.c_data), 32'(b.d));
      end
    end
    prev_cv = cb.c_valid;
    if ((cb.req_error & ~cb.req_ready) != '0)
      check("err_without_rdy", 32'(cb.req_error), 32'd0);
    if (cb.req_ready != '0) begin
      check("rdy_onehot", 32'($onehot(cb.req_ready)), 32'd1);
      id = -1;
      for (int i = 0; i < N; i++)
        if (cb.req_ready[i] && id < 0) id = i;
      done_cyc = cyc;
      done_log.push_back(cyc);
      if (cpl_q.size() == 0) begin
        check("cpl_unexpected", 32'd1, 32'd0);
      end else begin
        c       = cpl_q.pop_front();
        exp_err = c.err ? N'(1 << c.id) : '0;
        check("cpl_id", 32'(id), 32'(c.id));
        check("cpl_err", 32'(cb.req_error), 32'(exp_err));
      end
      if (rep[id] > 0) begin
        rep[id]--;
        rd[id] = rd[id] + 8'h11;
      end else begin
        rv[id] = 1'b0;
      end
      drive();
    end
  endtask

  task automatic drain(input int max);
    int k = 0;
    while ((cpl_q.size() != 0 || cb.busy) && k < max) begin
      step();
      k++;
    end
    if (k >= max) check("drain_bound", 32'(cpl_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rv    = '0;
    for (int i = 0; i < N; i++) begin
      ra[i]  = '0;
      rd[i]  = '0;
      rep[i] = 0;
    end
    drive();
    cpl_q.delete();
    beat_q.delete();
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    prev_cv = 1'b0;
    cyc     = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails + 1);
    $fatal(1);
  end

  initial begin
    int n;
    int cv;
    logic got;

    rv = '0;
    for (int i = 0; i < N; i++) begin
      ra[i]  = '0;
      rd[i]  = '0;
      rep[i] = 0;
    end
    drive();
    cb.c_ready    = 1'b1;
    cb2.req_addr  = '0;
    cb2.req_data  = '0;
    cb2.req_valid = '0;
    cb2.c_ready   = 1'b0;
    prev_cv       = 1'b0;

    @(negedge clk);
    check("rst_c_valid", 32'(cb.c_valid), 32'd0);
    check("rst_req_ready", 32'(cb.req_ready), 32'd0);
    check("rst_req_error", 32'(cb.req_error), 32'd0);
    check("rst_grant_id", 32'(cb.grant_id), 32'd0);
    check("rst_busy", 32'(cb.busy), 32'd0);
    check("rst_c_addr", 32'(cb.c_addr), 32'd0);
    check("rst_c_data", 32'(cb.c_data), 32'd0);

    // single legal request
    rst_n = 1'b1;
    cyc   = 0;
    post(0, 4'b0101, 8'hA5);
    expect_cpl(0, 1'b0, 4'b0101, 8'hA5);
    step();
    check("t1_c_valid_at1", 32'(cb.c_valid), 32'd1);
    check("t1_busy", 32'(cb.busy), 32'd1);
    check("t1_grant", 32'(cb.grant_id), 32'd0);
    drain(20);
    check("t1_rdy_at3", 32'(done_cyc), 32'd3);
    check("t1_idle_at4", 32'(cb.busy), 32'd0);

    // four requesters held, req0 asks twice
    do_reset();
    cb.c_ready = 1'b1;
    done_log.delete();
    post(0, 4'h4, 8'h10, 1);
    post(1, 4'h5, 8'h21);
    post(2, 4'h8, 8'h32);
    post(3, 4'hB, 8'h43);
    expect_cpl(0, 1'b0, 4'h4, 8'h10);
    expect_cpl(1, 1'b0, 4'h5, 8'h21);
    expect_cpl(2, 1'b0, 4'h8, 8'h32);
    expect_cpl(3, 1'b0, 4'hB, 8'h43);
    expect_cpl(0, 1'b0, 4'h4, 8'h21);
    drain(60);
    check("t2_cpl_count", 32'(done_log.size()), 32'd5);
    for (int k = 0; k < done_log.size(); k++)
      check("t2_rdy_cycle", 32'(done_log[k]), 32'(3 + 4*k));

    // illegal target on req2, then a normal request
    cyc      = 0;
    cv_cnt   = 0;
    done_cyc = -1;
    post(2, 4'b1100, 8'h33);
    expect_cpl(2, 1'b1, 4'b1100, 8'h33);
    drain(20);
    check("t3_no_c_valid", 32'(cv_cnt), 32'd0);
    check("t3_err_window", 32'(done_cyc >= 1 && done_cyc <= 2), 32'd1);
    cyc = 0;
    post(1, 4'h6, 8'h77);
    expect_cpl(1, 1'b0, 4'h6, 8'h77);
    drain(20);
    check("t3_next_rdy_at3", 32'(done_cyc), 32'd3);

    // target busy for 10 cycles after the beat
    cyc      = 0;
    done_cyc = -1;
    post(0, 4'h9, 8'h5C);
    expect_cpl(0, 1'b0, 4'h9, 8'h5C);
    step();
    step();
    cb.c_ready = 1'b0;
    repeat (9) step();
    check("t4_wait_busy", 32'(cb.busy), 32'd1);
    check("t4_no_rdy", 32'(cb.req_ready), 32'd0);
    check("t4_cpl_pending", 32'(cpl_q.size()), 32'd1);
    step();
    cb.c_ready = 1'b1;
    drain(20);
    check("t4_rdy_after_rise", 32'(done_cyc), 32'd13);

    // stuck target on the TIMEOUT=8 instance
    cb2.req_addr[A-1:0]  = 4'h5;
    cb2.req_data[D-1:0]  = 8'hC3;
    cb2.req_valid        = 4'b0001;
    n   = 0;
    cv  = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (cb2.c_valid) cv++;
      if (cb2.req_ready != '0) begin
        got = 1'b1;
        check("t5_rdy", 32'(cb2.req_ready), 32'd1);
        check("t5_err", 32'(cb2.req_error), 32'd1);
        cb2.req_valid = '0;
      end
    end
    check("t5_done", 32'(got), 32'd1);
    check("t5_c_valid_cycles", 32'(cv), 32'd8);
    check("t5_rdy_cycle", 32'(n), 32'd9);
    @(negedge clk);
    check("t5_idle", 32'(cb2.busy), 32'd0);

    // reset while waiting on the target
    cyc = 0;
    post(2, 4'h5, 8'h66);
    expect_cpl(2, 1'b0, 4'h5, 8'h66);
    step();
    step();
    cb.c_ready = 1'b0;
    check("t6_busy_before", 32'(cb.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_c_valid", 32'(cb.c_valid), 32'd0);
    check("t6_rst_busy", 32'(cb.busy), 32'd0);
    check("t6_rst_rdy", 32'(cb.req_ready), 32'd0);
    check("t6_rst_grant", 32'(cb.grant_id), 32'd0);
    cpl_q.delete();
    beat_q.delete();
    post(0, 4'h4, 8'h01);
    repeat (3) step();
    rst_n      = 1'b1;
    cb.c_ready = 1'b1;
    cyc        = 0;
    prev_cv    = 1'b0;
    expect_cpl(0, 1'b0, 4'h4, 8'h01);
    expect_cpl(2, 1'b0, 4'h5, 8'h66);
    drain(40);
    check("t6_second_rdy_at7", 32'(done_cyc), 32'd7);
    check("t6_sb_empty", 32'(cpl_q.size() + beat_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
